mu0_control: RTL

MU0_CONTROL -- requirements
Module: mu0_control

---
 rtl/mu0_pkg.sv | 36 +++
 rtl/mu0_control.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mu0_pkg.sv
// Shared types and constants for the MU0 control unit: FSM states, opcodes
// and ALU function codes.
package mu0_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_STO = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_JMP = 4'h4,
        OP_JGE = 4'h5,
        OP_JNE = 4'h6,
        OP_STP = 4'h7
    } opcode_t;

    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_SUB    = 2'b10;
    localparam logic [1:0] ALU_INC_X  = 2'b11;

    // ALU function for the three accumulator-loading memory instructions.
    function automatic logic [1:0] alu_fn_for(input logic [3:0] f);
        case (f)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS_Y;
        endcase
    endfunction

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer with combinational datapath
// controls and a registered retired-instruction counter.
module mu0_control
    import mu0_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
    input  logic        Mem_Rdy,
    output logic        X_sel,
    output logic        Y_sel,
    output logic        Addr_sel,
    output logic [1:0]  ALU_Fn,
    output logic        Acc_En,
    output logic        PC_En,
    output logic        IR_En,
    output logic        Rd,
    output logic        Wr,
    output logic        Halted,
    output logic [15:0] Instr_Count
);

    state_t      state;
    logic [15:0] count_q;
    logic        exec_done;

    assign Instr_Count = count_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases below infers a latch.
        X_sel     = 1'b0;
        Y_sel     = 1'b0;
        Addr_sel  = 1'b0;
        ALU_Fn    = ALU_PASS_Y;
        Acc_En    = 1'b0;
        PC_En     = 1'b0;
        IR_En     = 1'b0;
        Rd        = 1'b0;
        Wr        = 1'b0;
        exec_done = 1'b0;
        // Strobes are forced low while reset is held, whatever the state register shows.
        if (Reset) begin
            unique case (state)
                FETCH: begin
                    Rd     = 1'b1;
                    X_sel  = 1'b1;
                    ALU_Fn = ALU_INC_X;
                    IR_En  = Mem_Rdy;
                    PC_En  = Mem_Rdy;
                end
                EXEC: begin
                    case (F)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Addr_sel  = 1'b1;
                            Rd        = 1'b1;
                            ALU_Fn    = alu_fn_for(F);
                            Acc_En    = Mem_Rdy;
                            exec_done = Mem_Rdy;
                        end
                        OP_STO: begin
                            Addr_sel  = 1'b1;
                            Wr        = 1'b1;
                            exec_done = Mem_Rdy;
                        end
                        OP_JMP: begin
                            Y_sel     = 1'b1;
                            PC_En     = 1'b1;
                            exec_done = 1'b1;
                        end
                        OP_JGE: begin
                            Y_sel     = 1'b1;
                            PC_En     = ~N;
                            exec_done = 1'b1;
                        end
                        OP_JNE: begin
                            Y_sel     = 1'b1;
                            PC_En     = ~Z;
                            exec_done = 1'b1;
                        end
                        // STP and undefined opcodes retire in one cycle with no side effects.
                        default: exec_done = 1'b1;
                    endcase
                end
                HALT: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            state   <= FETCH;
            Halted  <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (Mem_Rdy) state <= EXEC;
                end
                EXEC: begin
                    if (exec_done) begin
                        count_q <= count_q + 16'd1;
                        if (F == OP_STP) begin
                            state  <= HALT;
                            Halted <= 1'b1;
                        end else begin
                            state  <= FETCH;
                        end
                    end
                end
                HALT: begin
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
